// File: rtl/sub_type_pipe_pkg.sv
// Shared types, limits and the elaboration-time legality check for sub_type_pipe.
package sub_type_pkg;

    // 24-bit signed bus used by reconstruction datapaths downstream of the adders.
    typedef logic signed [23:0] bus24_t;

    // Deepest pipeline the block is built for.
    localparam int LATENCY_MAX = 8;

    // Legal configuration: a non-empty data type, depth within 1..LATENCY_MAX,
    // and a counter at least one bit wide. real reports 64 bits here.
    function automatic bit cfg_legal(int dtype_bits, int latency, int cnt_w);
        return (dtype_bits >= 1) && (latency >= 1) &&
               (latency <= LATENCY_MAX) && (cnt_w >= 1);
    endfunction

endpackage

// File: rtl/sub_type_pipe_if.sv
// Valid/ready handshake bundle for sub_type_pipe: input side (sum, a) and
// output side (diff). The master is the source/sink around the pipe, the
// slave is the pipe itself.
interface sub_type_pipe_if #(
    parameter type DTYPE = logic
);
    // input side
    logic in_valid;
    logic in_ready;
    DTYPE sum;
    DTYPE a;
    // output side
    logic out_valid;
    logic out_ready;
    DTYPE diff;

    modport master (
        output in_valid, sum, a, out_ready,
        input  in_ready, out_valid, diff
    );

    modport slave (
        input  in_valid, sum, a, out_ready,
        output in_ready, out_valid, diff
    );
endinterface

// File: rtl/sub_type_pipe_stage.sv
// One valid/ready register stage of the subtractor pipeline. The load enable
// (this stage's ready) is computed by the parent so the ready chain never
// loops back through the stage instances.
module pipe_stage_type
    import sub_type_pkg::*;
#(
    parameter type DTYPE = logic
) (
    input  logic clk,
    input  logic rst,
    input  logic ld,        // stage is empty or downstream takes its item
    input  logic up_valid,
    input  DTYPE up_data,
    output logic dn_valid,
    output DTYPE dn_data
);

    logic vld_q, vld_d;
    DTYPE data_q, data_d;

    // Next state: follow the upstream stage when enabled, otherwise hold.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (ld) begin
            vld_d  = up_valid;
            data_d = up_data;
        end
    end

    // Stage registers; reset empties the stage and zeroes its data.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            data_q <= DTYPE'(0);
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign dn_valid = vld_q;
    assign dn_data  = data_q;

endmodule

// File: rtl/sub_type_pipe.sv
// Type-parameterized pipelined subtractor: diff = sum - a, LATENCY register
// stages with valid/ready on both sides, collapsing bubbles, plus a wrapping
// count of completed output transfers.
module sub_type_pipe
    import sub_type_pkg::*;
#(
    parameter type DTYPE   = logic,
    parameter int  LATENCY = 2,
    parameter int  CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    sub_type_pipe_if.slave   bus,
    output logic [CNT_W-1:0] xfer_count
);

    // Reject unsupported configurations while elaborating.
    if (!cfg_legal($bits(DTYPE), LATENCY, CNT_W)) begin : g_bad_cfg
        $error("sub_type_pipe: illegal DTYPE/LATENCY/CNT_W configuration");
    end

    logic [LATENCY-1:0] vld;          // per-stage valid
    logic [LATENCY-1:0] rdy;          // per-stage load enable
    DTYPE               dat [LATENCY];

    logic s0_vld_q, s0_vld_d;
    DTYPE s0_dat_q, s0_dat_d;
    DTYPE sub_res;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fire;

    // Ready chain rdy[i] = !v[i] || rdy[i+1], with rdy[LATENCY] = out_ready,
    // unrolled: a stage may load when downstream accepts or when any stage
    // from it to the output is empty. Depends only on flops and out_ready,
    // so in_ready has no path from in_valid.
    for (genvar i = 0; i < LATENCY; i++) begin : g_rdy
        assign rdy[i] = bus.out_ready | ~(&vld[LATENCY-1:i]);
    end

    // Native subtraction of DTYPE; integral types wrap to their width.
    assign sub_res = DTYPE'(bus.sum - bus.a);

    // Stage 0 next state: take in_valid when ready, capture data only with a valid input.
    always_comb begin
        s0_vld_d = s0_vld_q;
        s0_dat_d = s0_dat_q;
        if (rdy[0]) begin
            s0_vld_d = bus.in_valid;
            if (bus.in_valid) begin
                s0_dat_d = sub_res;
            end
        end
    end

    // Stage 0 registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_vld_q <= 1'b0;
            s0_dat_q <= DTYPE'(0);
        end else begin
            s0_vld_q <= s0_vld_d;
            s0_dat_q <= s0_dat_d;
        end
    end

    assign vld[0] = s0_vld_q;
    assign dat[0] = s0_dat_q;

    // Remaining stages are plain register slices.
    for (genvar i = 1; i < LATENCY; i++) begin : g_stage
        pipe_stage_type #(
            .DTYPE (DTYPE)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .ld       (rdy[i]),
            .up_valid (vld[i-1]),
            .up_data  (dat[i-1]),
            .dn_valid (vld[i]),
            .dn_data  (dat[i])
        );
    end

    // Output handshake and transfer counter.
    assign fire = vld[LATENCY-1] & bus.out_ready;

    // Count completed transfers; wraps naturally at 2^CNT_W.
    always_comb begin
        cnt_d = cnt_q;
        if (fire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register; a reset cycle never counts a transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.in_ready  = rdy[0];
    assign bus.out_valid = vld[LATENCY-1];
    assign bus.diff      = dat[LATENCY-1];
    assign xfer_count    = cnt_q;

endmodule

// File: tb/tb_sub_type_pipe.sv
// Directed bench for sub_type_pipe: logic, int, real and bus24_t instances,
// stalls, bubble collapse, counter wrap and mid-stream reset.
module tb_sub_type_pipe;
    import sub_type_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    sub_type_pipe_if #(.DTYPE(logic))   bl ();
    sub_type_pipe_if #(.DTYPE(int))     bi ();
    sub_type_pipe_if #(.DTYPE(real))    br ();
    sub_type_pipe_if #(.DTYPE(bus24_t)) bb ();
    sub_type_pipe_if #(.DTYPE(int))     bc ();

    logic [15:0] cnt_l, cnt_i, cnt_r, cnt_b;
    logic [1:0]  cnt_c;

    sub_type_pipe #(.DTYPE(logic), .LATENCY(2), .CNT_W(16)) u_l (
        .clk(clk), .rst(rst), .bus(bl), .xfer_count(cnt_l));
    sub_type_pipe #(.DTYPE(int), .LATENCY(2), .CNT_W(16)) u_i (
        .clk(clk), .rst(rst), .bus(bi), .xfer_count(cnt_i));
    sub_type_pipe #(.DTYPE(real), .LATENCY(2), .CNT_W(16)) u_r (
        .clk(clk), .rst(rst), .bus(br), .xfer_count(cnt_r));
    sub_type_pipe #(.DTYPE(bus24_t), .LATENCY(2), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .bus(bb), .xfer_count(cnt_b));
    sub_type_pipe #(.DTYPE(int), .LATENCY(3), .CNT_W(2)) u_c (
        .clk(clk), .rst(rst), .bus(bc), .xfer_count(cnt_c));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, longint obs, longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_r(string tag, real obs, real exp);
        checks++;
        assert (obs == exp) else begin
            failures++;
            $error("FAIL %s observed=%g expected=%g", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        bl.in_valid = 1'b0; bl.sum = 1'b0; bl.a = 1'b0; bl.out_ready = 1'b1;
        bi.in_valid = 1'b0; bi.sum = 0; bi.a = 0; bi.out_ready = 1'b1;
        br.in_valid = 1'b0; br.sum = 0.0; br.a = 0.0; br.out_ready = 1'b1;
        bb.in_valid = 1'b0; bb.sum = '0; bb.a = '0; bb.out_ready = 1'b1;
        bc.in_valid = 1'b0; bc.sum = 0; bc.a = 0; bc.out_ready = 1'b1;
        tick();
        tick();

        // reset state
        chk("rst_out_valid", longint'(bl.out_valid), 64'sd0);
        chk("rst_diff", longint'(bi.diff), 64'sd0);
        chk("rst_cnt", longint'(cnt_i), 64'sd0);
        chk("rst_in_ready", longint'(bi.in_ready), 64'sd1);
        rst = 1'b0;

        // 1-bit logic: 0 - 1 wraps to 1
        bl.in_valid = 1'b1; bl.sum = 1'b0; bl.a = 1'b1;
        tick();
        bl.in_valid = 1'b0;
        chk("l_not_yet", longint'(bl.out_valid), 64'sd0);
        tick();
        chk("l_out_valid", longint'(bl.out_valid), 64'sd1);
        chk("l_diff", longint'(bl.diff), 64'sd1);
        tick();
        chk("l_drained", longint'(bl.out_valid), 64'sd0);
        chk("l_cnt", longint'(cnt_l), 64'sd1);

        // int back-to-back stream
        bi.in_valid = 1'b1; bi.sum = 5; bi.a = 7;
        tick();
        chk("i_in_ready0", longint'(bi.in_ready), 64'sd1);
        bi.sum = 100; bi.a = -20;
        tick();
        chk("i_in_ready1", longint'(bi.in_ready), 64'sd1);
        chk("i_valid0", longint'(bi.out_valid), 64'sd1);
        chk("i_diff0", longint'(bi.diff), -64'sd2);
        bi.sum = 32'sh8000_0000; bi.a = 1;
        tick();
        chk("i_in_ready2", longint'(bi.in_ready), 64'sd1);
        chk("i_diff1", longint'(bi.diff), 64'sd120);
        bi.in_valid = 1'b0;
        tick();
        chk("i_valid2", longint'(bi.out_valid), 64'sd1);
        chk("i_diff2", longint'(bi.diff), 64'sd2147483647);
        tick();
        chk("i_drained", longint'(bi.out_valid), 64'sd0);
        chk("i_cnt", longint'(cnt_i), 64'sd3);

        // real
        br.in_valid = 1'b1; br.sum = 3.5; br.a = 1.25;
        tick();
        br.sum = 0.0; br.a = 0.1;
        tick();
        br.in_valid = 1'b0;
        chk("r_valid0", longint'(br.out_valid), 64'sd1);
        chk_r("r_diff0", br.diff, 2.25);
        tick();
        chk("r_valid1", longint'(br.out_valid), 64'sd1);
        chk_r("r_diff1", br.diff, -0.1);
        tick();
        chk("r_cnt", longint'(cnt_r), 64'sd2);

        // bus24_t stall: out_ready low for four cycles
        bb.out_ready = 1'b0; bb.in_valid = 1'b1; bb.sum = 24'sd1000; bb.a = 24'sd1;
        tick();
        chk("b_in_ready_c1", longint'(bb.in_ready), 64'sd1);
        bb.sum = -24'sd5; bb.a = 24'sd10;
        tick();
        chk("b_in_ready_c2", longint'(bb.in_ready), 64'sd0);
        chk("b_valid_c2", longint'(bb.out_valid), 64'sd1);
        chk("b_diff_c2", longint'(bb.diff), 64'sd999);
        bb.sum = 24'sd8388607; bb.a = -24'sd1;
        tick();
        chk("b_in_ready_c3", longint'(bb.in_ready), 64'sd0);
        chk("b_diff_c3", longint'(bb.diff), 64'sd999);
        tick();
        chk("b_in_ready_c4", longint'(bb.in_ready), 64'sd0);
        chk("b_diff_c4", longint'(bb.diff), 64'sd999);
        chk("b_cnt_stalled", longint'(cnt_b), 64'sd0);
        bb.out_ready = 1'b1;
        tick();
        bb.in_valid = 1'b0;
        chk("b_valid_r1", longint'(bb.out_valid), 64'sd1);
        chk("b_diff_r1", longint'(bb.diff), -64'sd15);
        tick();
        chk("b_valid_r2", longint'(bb.out_valid), 64'sd1);
        chk("b_diff_r2", longint'(bb.diff), -64'sd8388608);
        tick();
        chk("b_drained", longint'(bb.out_valid), 64'sd0);
        chk("b_cnt", longint'(cnt_b), 64'sd3);

        // bubble collapse, LATENCY=3
        bc.in_valid = 1'b1; bc.sum = 10; bc.a = 3;
        tick();
        bc.in_valid = 1'b0;
        tick();
        bc.in_valid = 1'b1; bc.sum = 3; bc.a = 10; bc.out_ready = 1'b0;
        tick();
        bc.in_valid = 1'b0;
        chk("c_valid_x", longint'(bc.out_valid), 64'sd1);
        chk("c_diff_x", longint'(bc.diff), 64'sd7);
        tick();
        chk("c_diff_hold1", longint'(bc.diff), 64'sd7);
        tick();
        chk("c_diff_hold2", longint'(bc.diff), 64'sd7);
        chk("c_cnt_stalled", longint'(cnt_c), 64'sd0);
        bc.out_ready = 1'b1;
        tick();
        chk("c_valid_y", longint'(bc.out_valid), 64'sd1);
        chk("c_diff_y", longint'(bc.diff), -64'sd7);
        tick();
        chk("c_drained", longint'(bc.out_valid), 64'sd0);
        chk("c_cnt2", longint'(cnt_c), 64'sd2);

        // counter wrap with CNT_W=2
        bc.in_valid = 1'b1; bc.sum = 1; bc.a = 1;
        tick();
        bc.sum = 2; bc.a = 1;
        tick();
        bc.in_valid = 1'b0;
        tick();
        tick();
        chk("c_cnt3", longint'(cnt_c), 64'sd3);
        chk("c_diff_q", longint'(bc.diff), 64'sd1);
        tick();
        chk("c_cnt_wrap", longint'(cnt_c), 64'sd0);

        // reset mid-stream with two items in flight
        bi.in_valid = 1'b1; bi.sum = 9; bi.a = 4;
        tick();
        bi.sum = 8; bi.a = 1;
        tick();
        bi.in_valid = 1'b0;
        chk("m_inflight", longint'(bi.out_valid), 64'sd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("m_out_valid", longint'(bi.out_valid), 64'sd0);
        chk("m_cnt", longint'(cnt_i), 64'sd0);
        chk("m_diff", longint'(bi.diff), 64'sd0);
        tick();
        chk("m_no_ghost", longint'(bi.out_valid), 64'sd0);
        bi.in_valid = 1'b1; bi.sum = 20; bi.a = 5;
        tick();
        bi.in_valid = 1'b0;
        tick();
        chk("m_new_valid", longint'(bi.out_valid), 64'sd1);
        chk("m_new_diff", longint'(bi.diff), 64'sd15);
        tick();
        chk("m_new_cnt", longint'(cnt_i), 64'sd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
